hit_judge: RTL and testbench

Downstream of the four per-lane one-pulse key stages. Consumes their single-cycle press pulses, judges each against the arrow currently in that lane's target row, and keeps the running score (BCD, for the HEX display driver) and the combo count. Also emits hit/miss pulses for the feedback LEDs.

---
 rtl/hit_judge.sv | 137 +++++++++++++
 tb/tb_hit_judge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hit_judge.sv
// Judges per-lane press pulses against the arrow in each lane's target row and
// keeps a saturating BCD score, a saturating combo count and registered hit/miss pulses.
module hit_judge #(
   parameter int LANES       = 4,
   parameter int DIGITS      = 4,
   parameter int COMBO_BONUS = 10
) (
   input  logic                CLOCK_50,
   input  logic                Reset,
   input  logic [LANES-1:0]    press,
   input  logic [LANES-1:0]    arrow_in_zone,
   input  logic [LANES-1:0]    arrow_leaving,
   input  logic                game_active,
   output logic [4*DIGITS-1:0] score,
   output logic [7:0]          combo,
   output logic                hit,
   output logic                miss,
   output logic [LANES-1:0]    lane_hit
);

   typedef enum logic [1:0] {
      EMPTY,
      ARMED,
      SCORED
   } lane_state_t;

   lane_state_t         r_state     [LANES];
   lane_state_t         w_stateNext [LANES];
   logic [4*DIGITS-1:0] r_score;
   logic [7:0]          r_combo;
   logic                r_hit;
   logic                r_miss;
   logic [LANES-1:0]    r_laneHit;

   logic [LANES-1:0]    w_laneHit;
   logic [LANES-1:0]    w_laneErr;
   logic [7:0]          w_hitCount;
   logic [7:0]          w_add;
   logic [7:0]          w_carry;
   logic [7:0]          w_digitSum;
   logic [4*DIGITS-1:0] w_scoreNext;
   logic [8:0]          w_comboSum;
   logic [7:0]          w_comboNext;

   // A press coinciding with arrow_leaving still scores; the lane then empties.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         w_stateNext[i] = r_state[i];
         w_laneHit[i]   = 1'b0;
         w_laneErr[i]   = 1'b0;
         if (!game_active) begin
            w_stateNext[i] = EMPTY;
         end else begin
            case (r_state[i])
               EMPTY: begin
                  w_laneErr[i] = press[i];
                  if (arrow_in_zone[i]) w_stateNext[i] = ARMED;
               end
               ARMED: begin
                  if (press[i]) begin
                     w_laneHit[i]   = 1'b1;
                     w_stateNext[i] = arrow_leaving[i] ? EMPTY : SCORED;
                  end else if (arrow_leaving[i]) begin
                     w_laneErr[i]   = 1'b1;
                     w_stateNext[i] = EMPTY;
                  end
               end
               SCORED: begin
                  if (arrow_leaving[i]) w_stateNext[i] = EMPTY;
               end
               default: w_stateNext[i] = EMPTY;
            endcase
         end
      end
   end

   always_comb begin
      w_hitCount = '0;
      for (int i = 0; i < LANES; i++) begin
         w_hitCount = w_hitCount + {7'd0, w_laneHit[i]};
      end
      w_add = (r_combo >= 8'(COMBO_BONUS)) ? (w_hitCount << 1) : w_hitCount;
   end

   // Ripple the add through the BCD digits; a carry out of the top digit pins the score at all nines.
   always_comb begin
      w_scoreNext = r_score;
      w_carry     = w_add;
      w_digitSum  = '0;
      for (int d = 0; d < DIGITS; d++) begin
         w_digitSum = {4'd0, r_score[4*d +: 4]} + w_carry;
         if (w_digitSum > 8'd9) begin
            w_digitSum = w_digitSum - 8'd10;
            w_carry    = 8'd1;
         end else begin
            w_carry    = 8'd0;
         end
         w_scoreNext[4*d +: 4] = w_digitSum[3:0];
      end
      if (w_carry != 8'd0) w_scoreNext = {DIGITS{4'h9}};
   end

   always_comb begin
      w_comboSum = {1'b0, r_combo} + {1'b0, w_hitCount};
      if (|w_laneErr)
         w_comboNext = 8'd0;
      else if (w_comboSum > 9'd255)
         w_comboNext = 8'd255;
      else
         w_comboNext = w_comboSum[7:0];
   end

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         for (int i = 0; i < LANES; i++) r_state[i] <= EMPTY;
         r_score   <= '0;
         r_combo   <= '0;
         r_hit     <= 1'b0;
         r_miss    <= 1'b0;
         r_laneHit <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) r_state[i] <= w_stateNext[i];
         r_score   <= w_scoreNext;
         r_combo   <= w_comboNext;
         r_hit     <= |w_laneHit;
         r_miss    <= |w_laneErr;
         r_laneHit <= w_laneHit;
      end
   end

   assign score    = r_score;
   assign combo    = r_combo;
   assign hit      = r_hit;
   assign miss     = r_miss;
   assign lane_hit = r_laneHit;

endmodule

// File: tb/tb_hit_judge.sv
// Randomized bench for hit_judge: a decimal-integer reference model of arrows,
// score and combo predicts every registered output after each clock edge.
module tb_hit_judge;

   localparam int LANES = 4;
   localparam int DIGITS = 4;
   localparam int BONUS = 10;

   logic          CLOCK_50 = 1'b0;
   logic          Reset;
   logic [3:0]    press;
   logic [3:0]    arrow_in_zone;
   logic [3:0]    arrow_leaving;
   logic          game_active;
   logic [15:0]   score;
   logic [7:0]    combo;
   logic          hit;
   logic          miss;
   logic [3:0]    lane_hit;

   int checkCount = 0;
   int failCount  = 0;

   bit   arrowHere [LANES];
   bit   alreadyHit [LANES];
   int   mScore;
   int   mCombo;
   bit   mHit;
   bit   mMiss;
   logic [3:0] mLaneHit;

   hit_judge #(.LANES(LANES), .DIGITS(DIGITS), .COMBO_BONUS(BONUS)) dut (
      .CLOCK_50      (CLOCK_50),
      .Reset         (Reset),
      .press         (press),
      .arrow_in_zone (arrow_in_zone),
      .arrow_leaving (arrow_leaving),
      .game_active   (game_active),
      .score         (score),
      .combo         (combo),
      .hit           (hit),
      .miss          (miss),
      .lane_hit      (lane_hit)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   function automatic logic [15:0] toBcd(input int value);
      logic [15:0] r;
      int v;
      r = '0;
      v = value;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         if (failCount <= 30)
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference behaviour: an arrow sits in the target row until it leaves; it can be hit once.
   task automatic modelStep(input bit rst, input bit act, input logic [3:0] pr, input logic [3:0] az, input logic [3:0] lv);
      int hits;
      int errs;
      int pts;
      hits = 0;
      errs = 0;
      mLaneHit = '0;
      if (rst) begin
         for (int i = 0; i < LANES; i++) begin
            arrowHere[i]  = 0;
            alreadyHit[i] = 0;
         end
         mScore = 0;
         mCombo = 0;
      end else if (!act) begin
         for (int i = 0; i < LANES; i++) begin
            arrowHere[i]  = 0;
            alreadyHit[i] = 0;
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (!arrowHere[i]) begin
               if (pr[i]) errs++;
               if (az[i]) begin
                  arrowHere[i]  = 1;
                  alreadyHit[i] = 0;
               end
            end else if (!alreadyHit[i]) begin
               if (pr[i]) begin
                  hits++;
                  mLaneHit[i] = 1'b1;
                  alreadyHit[i] = 1;
                  if (lv[i]) arrowHere[i] = 0;
               end else if (lv[i]) begin
                  errs++;
                  arrowHere[i] = 0;
               end
            end else if (lv[i]) begin
               arrowHere[i] = 0;
            end
         end
         pts = (mCombo >= BONUS) ? 2 : 1;
         mScore = mScore + hits * pts;
         if (mScore > 9999) mScore = 9999;
         if (errs > 0) mCombo = 0;
         else mCombo = (mCombo + hits > 255) ? 255 : mCombo + hits;
      end
      mHit  = (hits > 0);
      mMiss = (errs > 0);
   endtask

   // Drives one cycle's inputs, advances the model across the edge and compares just after it.
   task automatic applyStimulus(input bit rst, input bit act, input logic [3:0] pr, input logic [3:0] az, input logic [3:0] lv);
      Reset         = rst;
      game_active   = act;
      press         = pr;
      arrow_in_zone = az;
      arrow_leaving = lv;
      modelStep(rst, act, pr, az, lv);
      @(posedge CLOCK_50);
      #1;
      checkOutput("score", 32'(score), 32'(toBcd(mScore)));
      checkOutput("combo", 32'(combo), 32'(mCombo));
      checkOutput("hit", 32'(hit), 32'(mHit));
      checkOutput("miss", 32'(miss), 32'(mMiss));
      checkOutput("lane_hit", 32'(lane_hit), 32'(mLaneHit));
      @(negedge CLOCK_50);
   endtask

   function automatic logic [3:0] randMask(input int pct);
      logic [3:0] m;
      for (int i = 0; i < LANES; i++) m[i] = ($urandom_range(99) < pct);
      return m;
   endfunction

   task automatic randomPhase(input int cycles);
      bit rst;
      bit act;
      for (int c = 0; c < cycles; c++) begin
         rst = ($urandom_range(199) == 0);
         act = ($urandom_range(99) < 94);
         applyStimulus(rst, act, randMask(25), randMask(60), randMask(25));
      end
   endtask

   initial begin
      logic [3:0] m;
      int budget;
      Reset = 1'b1;
      game_active = 1'b0;
      press = '0;
      arrow_in_zone = '0;
      arrow_leaving = '0;
      @(negedge CLOCK_50);

      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      applyStimulus(1'b1, 1'b1, 4'hF, 4'hF, 4'hF);

      // Opening sequence: arm lane 0, then hit it.
      applyStimulus(1'b0, 1'b1, 4'h0, 4'h1, 4'h0);
      applyStimulus(1'b0, 1'b1, 4'h1, 4'h1, 4'h0);
      checkOutput("firstHitScore", 32'(score), 32'h0001);

      randomPhase(2000);

      // Clean streak: all lanes stay armed, random subsets hit and leave, no strays or misses.
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      applyStimulus(1'b0, 1'b1, 4'h0, 4'hF, 4'h0);
      budget = 0;
      while (mScore < 9999 && budget < 12000) begin
         m = 4'($urandom_range(15, 1));
         applyStimulus(1'b0, 1'b1, m, 4'hF, m);
         applyStimulus(1'b0, 1'b1, 4'h0, 4'hF, 4'h0);
         budget += 2;
      end
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b0, 1'b1, 4'hF, 4'hF, 4'hF);
         applyStimulus(1'b0, 1'b1, 4'h0, 4'hF, 4'h0);
      end
      checkOutput("scoreSaturated", 32'(score), 32'h9999);
      checkOutput("comboSaturated", 32'(combo), 32'd255);

      // Inactive game keeps the final score displayed.
      for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 4'hF, 4'hF, 4'h0);
      checkOutput("holdScore", 32'(score), 32'h9999);

      randomPhase(2000);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
